hpf_multichannel: RTL and testbench

- Parametrised successor to the single-channel Pan-Tompkins high-pass stage.
- Computes y[n] = x[n-D/2] - (1/D)*sum(k=0..D-1) x[n-k] per channel, with D = 2^LOG2_DEPTH. The sum is a recursive running sum, not a D-tap adder.
- Serves NUM_CH time-interleaved ECG leads, with a valid handshake, settle flag and synchronous clear.
- Sits between the band-limiting low-pass stage and the derivative stage.

---
 rtl/pt_filter_pkg.sv | 23 ++
 rtl/hpf_channel_state.sv | 48 ++++
 rtl/hpf_multichannel.sv | 111 +++++++++++
 tb/tb_hpf_multichannel.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pt_filter_pkg.sv
// Shared types, width helpers and legal parameter ranges for the
// Pan-Tompkins filter stages.
package pt_filter_pkg;

  localparam int DEFAULT_DATA_WIDTH = 11;

  localparam int LOG2_DEPTH_MIN = 1;
  localparam int LOG2_DEPTH_MAX = 8;
  localparam int NUM_CH_MIN     = 1;
  localparam int NUM_CH_MAX     = 16;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

  // Running-sum width: a full window of samples cannot overflow it.
  function automatic int acc_w(input int dw, input int l2d);
    return dw + l2d;
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/hpf_channel_state.sv
// History of one channel: delay line, running window sum and a saturating
// fill counter, all updated together when the channel accepts a sample.
module hpf_channel_state
  import pt_filter_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int LOG2_DEPTH = 5,
  localparam int ACC_W     = acc_w(DATA_WIDTH, LOG2_DEPTH),
  localparam int FILL_W    = LOG2_DEPTH + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    we,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic signed [ACC_W-1:0] sum_next,
  output logic signed [DATA_WIDTH-1:0] mid,
  output logic signed [DATA_WIDTH-1:0] last,
  output logic signed [ACC_W-1:0] sum,
  output logic [FILL_W-1:0]       fill
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic signed [DATA_WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < DEPTH; k++) taps[k] <= '0;
      sum  <= '0;
      fill <= '0;
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) taps[k] <= '0;
      sum  <= '0;
      fill <= '0;
    end else if (we) begin
      taps[0] <= din;
      for (int k = 1; k < DEPTH; k++) taps[k] <= taps[k-1];
      sum <= sum_next;
      if (fill != FILL_W'(DEPTH)) fill <= fill + 1'b1;
    end
  end

  // taps[k] holds x[n-1-k], so these are x[n-D/2] and x[n-D] for the next sample.
  assign mid  = taps[DEPTH/2-1];
  assign last = taps[DEPTH-1];

endmodule

// File: rtl/hpf_multichannel.sv
// Multichannel moving-average high-pass: y = x[n-D/2] - mean(last D samples),
// one registered output per accepted sample, channels time-interleaved.
module hpf_multichannel
  import pt_filter_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int LOG2_DEPTH = 5,
  parameter int NUM_CH     = 1,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic [CH_W-1:0]         in_ch,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [DATA_WIDTH:0]   out_data,
  output logic                    out_settled
);

  localparam int ACC_W  = acc_w(DATA_WIDTH, LOG2_DEPTH);
  localparam int Y_W    = ACC_W + 1;
  localparam int FILL_W = LOG2_DEPTH + 1;
  localparam int DEPTH  = 1 << LOG2_DEPTH;

  if (LOG2_DEPTH < LOG2_DEPTH_MIN || LOG2_DEPTH > LOG2_DEPTH_MAX) begin : g_bad_depth
    $error("hpf_multichannel: LOG2_DEPTH out of range");
  end
  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_ch
    $error("hpf_multichannel: NUM_CH out of range");
  end

  logic                         ch_ok;
  logic                         acc;
  logic [NUM_CH-1:0]            we;
  logic signed [DATA_WIDTH-1:0] mid_arr  [NUM_CH];
  logic signed [DATA_WIDTH-1:0] last_arr [NUM_CH];
  logic signed [ACC_W-1:0]      sum_arr  [NUM_CH];
  logic [FILL_W-1:0]            fill_arr [NUM_CH];

  logic signed [DATA_WIDTH-1:0] mid_sel;
  logic signed [DATA_WIDTH-1:0] last_sel;
  logic signed [ACC_W-1:0]      sum_sel;
  logic [FILL_W-1:0]            fill_sel;
  logic signed [ACC_W-1:0]      sum_next;
  logic signed [Y_W-1:0]        y_full;
  logic                         settled_next;

  assign ch_ok = ({1'b0, in_ch} < (CH_W+1)'(NUM_CH));
  assign acc   = en & in_valid & ~clr & ch_ok;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign we[c] = acc && (in_ch == CH_W'(c));

    hpf_channel_state #(
      .DATA_WIDTH (DATA_WIDTH),
      .LOG2_DEPTH (LOG2_DEPTH)
    ) u_state (
      .clk      (clk),
      .rstn     (rstn),
      .clr      (clr),
      .we       (we[c]),
      .din      (in_data),
      .sum_next (sum_next),
      .mid      (mid_arr[c]),
      .last     (last_arr[c]),
      .sum      (sum_arr[c]),
      .fill     (fill_arr[c])
    );
  end

  always_comb begin
    mid_sel  = '0;
    last_sel = '0;
    sum_sel  = '0;
    fill_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_ch == CH_W'(i)) begin
        mid_sel  = mid_arr[i];
        last_sel = last_arr[i];
        sum_sel  = sum_arr[i];
        fill_sel = fill_arr[i];
      end
    end
  end

  // Recursive window sum; the scaled difference keeps full precision until the final floor shift.
  assign sum_next     = sum_sel + ACC_W'(in_data) - ACC_W'(last_sel);
  assign y_full       = (Y_W'(mid_sel) <<< LOG2_DEPTH) - Y_W'(sum_next);
  assign settled_next = (fill_sel >= FILL_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out_data    <= '0;
      out_settled <= 1'b0;
    end else if (acc) begin
      out_valid   <= 1'b1;
      out_ch      <= in_ch;
      out_data    <= (DATA_WIDTH+1)'(y_full >>> LOG2_DEPTH);
      out_settled <= settled_next;
    end else begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hpf_multichannel.sv
// Scoreboard bench for hpf_multichannel: stimulus pushes expected samples,
// a negedge monitor pops and compares every out_valid beat.
module tb_hpf_multichannel;

  localparam int DW        = 11;
  localparam int L2D       = 5;
  localparam int NCH       = 5;
  localparam int CHW       = 3;
  localparam int DEPTH     = 32;
  localparam int HAND_NONE = 2147483647;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 en;
  logic                 clr;
  logic                 in_valid;
  logic [CHW-1:0]       in_ch;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic [CHW-1:0]       out_ch;
  logic signed [DW:0]   out_data;
  logic                 out_settled;

  typedef struct {
    int ch;
    int data;
    bit settled;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   beat   = 0;
  int   hist [NCH][0:1023];
  int   cnt  [NCH];

  hpf_multichannel #(
    .DATA_WIDTH (DW),
    .LOG2_DEPTH (L2D),
    .NUM_CH     (NCH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ch       (in_ch),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ch      (out_ch),
    .out_data    (out_data),
    .out_settled (out_settled)
  );

  always #5 clk = ~clk;

  // Hand formulas: constant 100 and a single 64 impulse into an empty window.
  function automatic int dc_y(input int n);
    int v;
    v = ((n < 16) ? 0 : 3200) - 100 * ((n < 32) ? (n + 1) : 32);
    return v >>> 5;
  endfunction

  function automatic int impulse_y(input int n);
    if (n >= 32) return 0;
    return (n == 16) ? 62 : -2;
  endfunction

  // Direct (non-recursive) window evaluation over the stored history.
  function automatic int model_y(input int ch);
    int n, mid, sum, v;
    n   = cnt[ch] - 1;
    mid = (n >= 16) ? hist[ch][n-16] : 0;
    sum = 0;
    for (int k = 0; k < DEPTH; k++)
      if (n - k >= 0) sum += hist[ch][n-k];
    v = mid * 32 - sum;
    return v >>> 5;
  endfunction

  task automatic check_output(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic apply_stimulus(input bit v, input bit e, input bit c,
                                input int ch, input int data, input int hand);
    exp_t x;
    in_valid = v;
    en       = e;
    clr      = c;
    in_ch    = CHW'(ch);
    in_data  = DW'(data);
    if (c) begin
      for (int i = 0; i < NCH; i++) cnt[i] = 0;
    end else if (v && e && ch >= 0 && ch < NCH && cnt[ch] < 1024) begin
      hist[ch][cnt[ch]] = data;
      cnt[ch]++;
      x.ch      = ch;
      x.data    = (hand == HAND_NONE) ? model_y(ch) : hand;
      x.settled = (cnt[ch] >= DEPTH);
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b1, 1'b0, 0, 0, HAND_NONE);
  endtask

  task automatic clear_all();
    apply_stimulus(1'b0, 1'b1, 1'b1, 0, 0, HAND_NONE);
  endtask

  always @(negedge clk) begin
    if (rstn && out_valid) begin
      exp_t e;
      checks++;
      beat++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_out_valid#%0d: got ch=%0d data=%0d, expected no output",
                 beat, out_ch, out_data);
      end else begin
        e = exp_q.pop_front();
        if (int'(out_ch) != e.ch || int'(out_data) != e.data || out_settled != e.settled) begin
          errors++;
          $display("[TB] FAIL out_sample#%0d: got ch=%0d data=%0d settled=%0d, expected ch=%0d data=%0d settled=%0d",
                   beat, out_ch, out_data, out_settled, e.ch, e.data, e.settled);
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rstn = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    #12;
    check_output("reset_out_valid",   int'(out_valid),   0);
    check_output("reset_out_ch",      int'(out_ch),      0);
    check_output("reset_out_data",    int'(out_data),    0);
    check_output("reset_out_settled", int'(out_settled), 0);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] DC 100 on channel 0");
    for (int n = 0; n < 40; n++) apply_stimulus(1, 1, 0, 0, 100, dc_y(n));
    clear_all();

    $display("[TB] impulse 64 on channel 0");
    for (int n = 0; n < 40; n++) apply_stimulus(1, 1, 0, 0, (n == 0) ? 64 : 0, impulse_y(n));
    clear_all();

    $display("[TB] round-robin interleave");
    for (int r = 0; r < 40; r++)
      for (int c = 0; c < NCH; c++)
        apply_stimulus(1, 1, 0, c, (c == 0 && r == 0) ? 64 : 0, (c == 0) ? impulse_y(r) : 0);
    clear_all();

    $display("[TB] sparse valid with enable toggling");
    for (int n = 0; n < 40; n++) begin
      apply_stimulus(1, 1, 0, 1, 100, dc_y(n));
      apply_stimulus(0, 1, 0, 1, 55, HAND_NONE);
      apply_stimulus(1, 0, 0, 1, 77, HAND_NONE);
    end
    clear_all();

    $display("[TB] synchronous clear mid-stream");
    for (int n = 0; n < 20; n++) apply_stimulus(1, 1, 0, 0, 100, dc_y(n));
    apply_stimulus(1, 1, 1, 0, 100, HAND_NONE);
    for (int n = 0; n < 20; n++) apply_stimulus(1, 1, 0, 0, 100, dc_y(n));
    idle();

    $display("[TB] asynchronous reset mid-stream");
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check_output("async_reset_out_valid",   int'(out_valid),   0);
    check_output("async_reset_out_ch",      int'(out_ch),      0);
    check_output("async_reset_out_data",    int'(out_data),    0);
    check_output("async_reset_out_settled", int'(out_settled), 0);
    #1 rstn = 1'b1;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    @(posedge clk);
    #1;
    for (int n = 0; n < 5; n++) apply_stimulus(1, 1, 0, 0, 100, dc_y(n));
    clear_all();

    $display("[TB] full-scale alternation and out-of-range channels");
    for (int n = 0; n < 40; n++) apply_stimulus(1, 1, 0, 2, (n % 2 == 0) ? -1024 : 1023, HAND_NONE);
    apply_stimulus(1, 1, 0, 5, 300, HAND_NONE);
    apply_stimulus(1, 1, 0, 6, -300, HAND_NONE);
    apply_stimulus(1, 1, 0, 7, 1000, HAND_NONE);
    apply_stimulus(1, 1, 0, 2, -1024, HAND_NONE);
    apply_stimulus(1, 1, 0, 2, -1024, HAND_NONE);

    repeat (3) idle();
    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
